// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back mux, MEM/WB operand forwarding
// selects and a saturating counter of retired register-writing instructions.
module mem_wb_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             flush,
    input  logic             mem_read_in,
    input  logic             WB_Enable_in,
    input  logic [3:0]       RD_in,
    input  logic [31:0]      ALU_result_in,
    input  logic [31:0]      mem_read_data_in,
    input  logic             fwd_en,
    input  logic [3:0]       src1,
    input  logic [3:0]       src2,
    output logic             WB_Enable,
    output logic [3:0]       WB_Dest,
    output logic [31:0]      WB_Value,
    output logic [1:0]       sel_src1,
    output logic [1:0]       sel_src2,
    output logic [CNT_W-1:0] retire_cnt
);

    logic             valid_q, valid_d;
    logic             mem_read_q, mem_read_d;
    logic             wb_en_q, wb_en_d;
    logic [3:0]       rd_q, rd_d;
    logic [31:0]      alu_q, alu_d;
    logic [31:0]      mdata_q, mdata_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    // A held (frozen) instruction must not write until the SRAM releases it.
    assign WB_Enable  = wb_en_q & valid_q & ~freeze;
    assign WB_Dest    = rd_q;
    assign WB_Value   = mem_read_q ? mdata_q : alu_q;
    assign retire_cnt = retire_cnt_q;

    // Newest producer wins; a load still in MEM has no data yet, so it never matches.
    function automatic logic [1:0] fwd_sel(
        input logic       en,
        input logic       mem_wb,
        input logic       mem_ld,
        input logic [3:0] mem_rd,
        input logic       wb_wr,
        input logic [3:0] wb_rd,
        input logic [3:0] src
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (en && mem_wb && !mem_ld && (mem_rd == src)) begin
            sel = 2'b01;
        end else if (en && wb_wr && (wb_rd == src)) begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    always_comb begin
        sel_src1 = fwd_sel(fwd_en, WB_Enable_in, mem_read_in, RD_in, WB_Enable, WB_Dest, src1);
        sel_src2 = fwd_sel(fwd_en, WB_Enable_in, mem_read_in, RD_in, WB_Enable, WB_Dest, src2);
    end

    always_comb begin
        valid_d      = valid_q;
        mem_read_d   = mem_read_q;
        wb_en_d      = wb_en_q;
        rd_d         = rd_q;
        alu_d        = alu_q;
        mdata_d      = mdata_q;
        retire_cnt_d = retire_cnt_q;
        if (!freeze) begin
            if (WB_Enable && (retire_cnt_q != {CNT_W{1'b1}})) begin
                retire_cnt_d = retire_cnt_q + CNT_W'(1);
            end
            // A bubble only clears the control bits; stale data is never used.
            if (flush) begin
                valid_d    = 1'b0;
                mem_read_d = 1'b0;
                wb_en_d    = 1'b0;
            end else begin
                valid_d    = 1'b1;
                mem_read_d = mem_read_in;
                wb_en_d    = WB_Enable_in;
                rd_d       = RD_in;
                alu_d      = ALU_result_in;
                mdata_d    = mem_read_data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q      <= 1'b0;
            mem_read_q   <= 1'b0;
            wb_en_q      <= 1'b0;
            rd_q         <= 4'd0;
            alu_q        <= 32'd0;
            mdata_q      <= 32'd0;
            retire_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            mem_read_q   <= mem_read_d;
            wb_en_q      <= wb_en_d;
            rd_q         <= rd_d;
            alu_q        <= alu_d;
            mdata_q      <= mdata_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios then random traffic,
// compared against an instruction-level model of the write-back stage.
module tb_mem_wb_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        flush;
    logic        mem_read_in;
    logic        WB_Enable_in;
    logic [3:0]  RD_in;
    logic [31:0] ALU_result_in;
    logic [31:0] mem_read_data_in;
    logic        fwd_en;
    logic [3:0]  src1;
    logic [3:0]  src2;

    logic        WB_Enable, WB_Enable_s;
    logic [3:0]  WB_Dest, WB_Dest_s;
    logic [31:0] WB_Value, WB_Value_s;
    logic [1:0]  sel_src1, sel_src1_s;
    logic [1:0]  sel_src2, sel_src2_s;
    logic [15:0] retire_cnt16;
    logic [1:0]  retire_cnt2;

    int checks;
    int failures;

    // Model: the instruction sitting in WB, plus retire totals.
    bit          m_valid;
    bit          m_load;
    bit          m_wb;
    logic [3:0]  m_rd;
    logic [31:0] m_alu;
    logic [31:0] m_mdata;
    bit          m_known;
    int          m_ret16;
    int          m_ret2;

    mem_wb_stage #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .mem_read_in(mem_read_in), .WB_Enable_in(WB_Enable_in), .RD_in(RD_in),
        .ALU_result_in(ALU_result_in), .mem_read_data_in(mem_read_data_in),
        .fwd_en(fwd_en), .src1(src1), .src2(src2),
        .WB_Enable(WB_Enable), .WB_Dest(WB_Dest), .WB_Value(WB_Value),
        .sel_src1(sel_src1), .sel_src2(sel_src2), .retire_cnt(retire_cnt16)
    );

    mem_wb_stage #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .mem_read_in(mem_read_in), .WB_Enable_in(WB_Enable_in), .RD_in(RD_in),
        .ALU_result_in(ALU_result_in), .mem_read_data_in(mem_read_data_in),
        .fwd_en(fwd_en), .src1(src1), .src2(src2),
        .WB_Enable(WB_Enable_s), .WB_Dest(WB_Dest_s), .WB_Value(WB_Value_s),
        .sel_src1(sel_src1_s), .sel_src2(sel_src2_s), .retire_cnt(retire_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit expWbEn();
        return m_valid && m_wb && !freeze;
    endfunction

    function automatic logic [1:0] expSel(input logic [3:0] src);
        if (!fwd_en) return 2'b00;
        if (WB_Enable_in && !mem_read_in && RD_in == src) return 2'b01;
        if (expWbEn() && m_rd == src) return 2'b10;
        return 2'b00;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_wb_en"}, 32'(WB_Enable), 32'(expWbEn()));
        checkOutput({tag, "_wb_en_s"}, 32'(WB_Enable_s), 32'(expWbEn()));
        if (m_known) begin
            checkOutput({tag, "_dest"}, 32'(WB_Dest), 32'(m_rd));
            checkOutput({tag, "_value"}, WB_Value, m_load ? m_mdata : m_alu);
        end
        checkOutput({tag, "_sel1"}, 32'(sel_src1), 32'(expSel(src1)));
        checkOutput({tag, "_sel2"}, 32'(sel_src2), 32'(expSel(src2)));
        checkOutput({tag, "_cnt16"}, 32'(retire_cnt16), 32'(m_ret16));
        checkOutput({tag, "_cnt2"}, 32'(retire_cnt2), 32'(m_ret2));
    endtask

    task automatic applyStimulus(input bit r, input bit fz, input bit fl, input bit mr,
                                 input bit we, input logic [3:0] rd, input logic [31:0] alu,
                                 input logic [31:0] md, input bit fe,
                                 input logic [3:0] s1, input logic [3:0] s2);
        rst = r; freeze = fz; flush = fl; mem_read_in = mr; WB_Enable_in = we;
        RD_in = rd; ALU_result_in = alu; mem_read_data_in = md;
        fwd_en = fe; src1 = s1; src2 = s2;
    endtask

    task automatic updateModel();
        bit en;
        en = expWbEn();
        if (!rst) begin
            m_valid = 0; m_load = 0; m_wb = 0; m_rd = '0; m_alu = '0; m_mdata = '0;
            m_known = 1; m_ret16 = 0; m_ret2 = 0;
        end else if (!freeze) begin
            if (en) begin
                m_ret16 = (m_ret16 < 65535) ? m_ret16 + 1 : 65535;
                m_ret2  = (m_ret2 < 3) ? m_ret2 + 1 : 3;
            end
            if (flush) begin
                m_valid = 0; m_load = 0; m_wb = 0; m_known = 0;
            end else begin
                m_valid = 1; m_load = mem_read_in; m_wb = WB_Enable_in; m_rd = RD_in;
                m_alu = ALU_result_in; m_mdata = mem_read_data_in; m_known = 1;
            end
        end
    endtask

    task automatic runCycle(input string tag);
        #1;
        checkAll(tag);
        @(posedge clk);
        updateModel();
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1, 0, 0, 0, 0, 4'd0, 32'd0, 32'd0, 0, 4'd0, 4'd0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        m_valid = 0; m_load = 0; m_wb = 0; m_rd = '0; m_alu = '0; m_mdata = '0;
        m_known = 0; m_ret16 = 0; m_ret2 = 0;

        @(negedge clk);
        applyStimulus(0, 1, 1, 0, 0, 4'd0, 32'd0, 32'd0, 0, 4'd0, 4'd0);
        @(posedge clk);
        updateModel();
        @(negedge clk);
        idle();
        #1;
        checkOutput("reset_wb_en", 32'(WB_Enable), 32'd0);
        checkOutput("reset_dest", 32'(WB_Dest), 32'd0);
        checkOutput("reset_value", WB_Value, 32'd0);
        checkOutput("reset_sel1", 32'(sel_src1), 32'd0);
        checkOutput("reset_cnt", 32'(retire_cnt16), 32'd0);
        runCycle("reset");

        applyStimulus(1, 0, 0, 0, 1, 4'd3, 32'h55, 32'h0, 0, 4'd0, 4'd0);
        runCycle("alu_in");
        idle();
        #1;
        checkOutput("alu_wb_en", 32'(WB_Enable), 32'd1);
        checkOutput("alu_dest", 32'(WB_Dest), 32'd3);
        checkOutput("alu_value", WB_Value, 32'h55);
        runCycle("alu_out");
        checkOutput("alu_cnt", 32'(retire_cnt16), 32'd1);

        applyStimulus(1, 0, 0, 1, 1, 4'd7, 32'h400, 32'hDEADBEEF, 0, 4'd0, 4'd0);
        runCycle("load_in");
        idle();
        #1;
        checkOutput("load_value", WB_Value, 32'hDEADBEEF);
        runCycle("load_out");

        applyStimulus(1, 0, 0, 0, 1, 4'd9, 32'h1234, 32'h0, 0, 4'd0, 4'd0);
        runCycle("pre_freeze");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, i[0], 0, 1, 4'(i + 1), $urandom, $urandom, 0, 4'd0, 4'd0);
            #1;
            checkOutput("freeze_wb_en", 32'(WB_Enable), 32'd0);
            checkOutput("freeze_dest", 32'(WB_Dest), 32'd9);
            checkOutput("freeze_value", WB_Value, 32'h1234);
            runCycle("freeze");
        end
        idle();
        #1;
        checkOutput("release_wb_en", 32'(WB_Enable), 32'd1);
        checkOutput("release_dest", 32'(WB_Dest), 32'd9);
        runCycle("release");
        runCycle("after_release");

        applyStimulus(1, 0, 0, 0, 1, 4'd5, 32'hA5, 32'h0, 1, 4'd5, 4'd5);
        runCycle("fwd_seed");
        applyStimulus(1, 0, 0, 0, 1, 4'd5, 32'hB6, 32'h0, 1, 4'd5, 4'd5);
        #1;
        checkOutput("fwd_mem_sel1", 32'(sel_src1), 32'd1);
        checkOutput("fwd_mem_sel2", 32'(sel_src2), 32'd1);
        mem_read_in = 1;
        #1;
        checkOutput("fwd_wb_sel1", 32'(sel_src1), 32'd2);
        checkOutput("fwd_wb_sel2", 32'(sel_src2), 32'd2);
        fwd_en = 0;
        #1;
        checkOutput("fwd_off_sel1", 32'(sel_src1), 32'd0);
        checkOutput("fwd_off_sel2", 32'(sel_src2), 32'd0);
        runCycle("fwd_step");

        applyStimulus(1, 0, 1, 0, 1, 4'd2, 32'h77, 32'h0, 0, 4'd0, 4'd0);
        runCycle("flush_in");
        idle();
        #1;
        checkOutput("flush_wb_en", 32'(WB_Enable), 32'd0);
        runCycle("flush_out");
        applyStimulus(1, 0, 0, 0, 1, 4'd4, 32'h88, 32'h0, 0, 4'd0, 4'd0);
        runCycle("ff_seed");
        applyStimulus(1, 1, 1, 0, 0, 4'd0, 32'h0, 32'h0, 0, 4'd0, 4'd0);
        runCycle("flush_freeze");
        idle();
        #1;
        checkOutput("ff_held_wb_en", 32'(WB_Enable), 32'd1);
        checkOutput("ff_held_dest", 32'(WB_Dest), 32'd4);
        runCycle("ff_release");

        applyStimulus(1, 0, 0, 0, 1, 4'd6, 32'h99, 32'h0, 0, 4'd0, 4'd0);
        runCycle("rstfz_seed");
        applyStimulus(0, 1, 0, 0, 1, 4'd6, 32'h99, 32'h0, 0, 4'd0, 4'd0);
        runCycle("rst_in_freeze");
        idle();
        #1;
        checkOutput("rstfz_wb_en", 32'(WB_Enable), 32'd0);
        checkOutput("rstfz_cnt", 32'(retire_cnt16), 32'd0);
        runCycle("rstfz_after");

        for (int i = 0; i < 7; i++) begin
            applyStimulus(1, 0, 0, 0, 1, 4'(i), 32'(i), 32'h0, 0, 4'd0, 4'd0);
            runCycle("sat");
        end
        checkOutput("sat_cnt2", 32'(retire_cnt2), 32'd3);
        checkOutput("sat_cnt16", 32'(retire_cnt16), 32'd6);
        applyStimulus(0, 0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 0, 4'd0, 4'd0);
        runCycle("sat_rst");
        idle();
        #1;
        checkOutput("sat_rst_cnt2", 32'(retire_cnt2), 32'd0);

        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 39) != 0, $urandom_range(0, 3) == 0,
                          $urandom_range(0, 5) == 0, 1'($urandom), 1'($urandom),
                          4'($urandom_range(0, 3)), $urandom, $urandom,
                          $urandom_range(0, 4) != 0,
                          4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
            runCycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
